axi_sram_slave: RTL
===================

Name: axi_sram_slave

Overview:
AXI3 responder backed by a word-organised on-chip RAM: the slave end of the bus that the data-side master drives. It accepts single-beat and burst (up to 16 beats) reads and writes with byte strobes. It serves as the simulation/FPGA memory model behind the CPU AXI ports. Read and write channels run independent FSMs against a dual-port register array, so one read burst and one write burst can be in flight at the same time.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH words of 32 bits.
INIT_ZERO, 1, 1 = RAM cleared to 0 at time zero (not on reset).

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
s_arid  in  4  read ID
s_araddr  in  32  read byte address
s_arlen  in  4  beats-1
s_arsize  in  3  bytes/beat code
s_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
s_arvalid  in  1  read address valid
s_arready  out  1  read address accepted
s_rid  out  4  echoed arid
s_rdata  out  32  read data
s_rresp  out  2  00 OKAY, 10 SLVERR
s_rlast  out  1  last read beat
s_rvalid  out  1  read data valid
s_rready  in  1  master accepts read beat
s_awid  in  4  write ID
s_awaddr  in  32  write byte address
s_awlen  in  4  beats-1
s_awsize  in  3  bytes/beat code
s_awburst  in  2  burst type
s_awvalid  in  1  write address valid
s_awready  out  1  write address accepted
s_wdata  in  32  write data
s_wstrb  in  4  byte enables
s_wlast  in  1  last write beat
s_wvalid  in  1  write data valid
s_wready  out  1  write data accepted
s_bid  out  4  echoed awid
s_bresp  out  2  write response
s_bvalid  out  1  write response valid
s_bready  in  1  master accepts response

Behaviour:
- Reset (async, resetn=0): all outputs 0, both FSMs to IDLE, RAM contents untouched. s_arready/s_awready rise at the first clk edge after resetn deasserts.
- Word index = addr[ADDR_WIDTH+1:2]. Upper bits are ignored (aliasing). addr[1:0] is ignored.
- Beat address advance, modulo RAM depth:
  - FIXED: address held.
  - INCR: +1 word.
  - WRAP: +1 word within a (len+1)-word aligned window; low log2(len+1) index bits wrap. WRAP with len not in {1,3,7,15} is treated as INCR.
- Size error: size != 3'b010 gives resp = 2'b10 on every beat. Reads of an errored burst return 0; writes of an errored burst do not touch the RAM.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: arready=1. On arvalid&arready, latch id/addr/len/burst/size, load rdata from RAM[addr], go R_DATA. rvalid=1 in the next cycle (1-cycle latency).
  - R_DATA: arready=0, rvalid=1, rlast=(beat==len).
  - rvalid&~rready: rdata/rresp/rlast/rid held stable.
  - rvalid&rready and not last: advance address, load next word.
  - rvalid&rready and last: rvalid drops, go R_IDLE (arready=1 next cycle).
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: awready=1, wready=0; W-before-AW waits. On aw handshake, latch fields, go W_DATA.
  - W_DATA: wready=1. Each wvalid&wready writes the strobe-selected bytes at the current address, then advances.
  - Burst ends at the first of wlast=1 or beat==awlen. If the two do not coincide, bresp=2'b10. Go W_RESP.
  - W_RESP: bvalid=1, bid=latched id, wready=0. On bready, go W_IDLE.
  - s_wid does not exist; write ordering is strictly in-order, one burst at a time.
- Read/write collision on the same word in the same edge: the read loads the pre-write (old) value; the write then takes effect.
- resetn asserted mid-burst: the transfer is abandoned immediately; no response is issued for it; RAM writes already committed remain.

Test Plan:
- Single write then read: AW 0x100, len 0, wdata 0xDEADBEEF, strb 1111 -> bresp 00, bid echoed; AR 0x100 -> rdata 0xDEADBEEF, rlast=1, rvalid exactly 1 cycle after ar handshake.
- 8-beat INCR burst: write 0x200 with words 0..7, read back with rready toggling 1/0 each cycle -> data 0..7 in order, held stable while rready=0, rlast only on beat 7.
- WRAP len 3 read at 0x308 after writing A,B,C,D to 0x300..0x30C -> returns C,D,A,B.
- Byte strobes: word 0x11223344, then write 0xAABBCCDD with strb 0101 -> reads 0x11BB33DD.
- Protocol errors:
  - early wlast on beat 2 of a len-3 burst -> bresp 10, bvalid after beat 2.
  - arsize 3'b001 -> every beat rresp 10, rdata 0.
- Concurrency and reset:
  - read and write bursts overlapping the same word -> read beat issued on the write edge returns old data.
  - resetn pulsed mid read burst -> rvalid 0 asynchronously; arready 1 one edge after release.

Source files
------------

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 responder over a 32-bit word RAM.
// Independent read and write FSMs share a dual-port register array.
module axi_sram_slave #(
   parameter int ADDR_WIDTH = 10,
   parameter bit INIT_ZERO  = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [3:0]  s_arid,
   input  logic [31:0] s_araddr,
   input  logic [3:0]  s_arlen,
   input  logic [2:0]  s_arsize,
   input  logic [1:0]  s_arburst,
   input  logic        s_arvalid,
   output logic        s_arready,
   output logic [3:0]  s_rid,
   output logic [31:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        s_rlast,
   output logic        s_rvalid,
   input  logic        s_rready,
   input  logic [3:0]  s_awid,
   input  logic [31:0] s_awaddr,
   input  logic [3:0]  s_awlen,
   input  logic [2:0]  s_awsize,
   input  logic [1:0]  s_awburst,
   input  logic        s_awvalid,
   output logic        s_awready,
   input  logic [31:0] s_wdata,
   input  logic [3:0]  s_wstrb,
   input  logic        s_wlast,
   input  logic        s_wvalid,
   output logic        s_wready,
   output logic [3:0]  s_bid,
   output logic [1:0]  s_bresp,
   output logic        s_bvalid,
   input  logic        s_bready
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   typedef logic [ADDR_WIDTH-1:0] idx_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

   logic [31:0] r_mem [DEPTH] = '{default: (INIT_ZERO ? 32'h0 : 32'hx)};

   // WRAP only for power-of-two lengths; low index bits roll over
   function automatic idx_t f_next(idx_t i, logic [3:0] len, logic [1:0] burst);
      idx_t m;
      m = idx_t'(len);
      if (burst == 2'b00)
         f_next = i;
      else if (burst == 2'b10 &&
               (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15))
         f_next = (i & ~m) | ((i + idx_t'(1)) & m);
      else
         f_next = i + idx_t'(1);
   endfunction

   logic w_unused;
   assign w_unused = ^{s_araddr[31:ADDR_WIDTH+2], s_araddr[1:0],
                       s_awaddr[31:ADDR_WIDTH+2], s_awaddr[1:0]};

   rstate_t     r_rstate, w_rstate_n;
   logic        r_arready, w_arready_n;
   logic        r_rvalid, w_rvalid_n;
   logic        r_rlast, w_rlast_n;
   logic [3:0]  r_rid, w_rid_n;
   logic [31:0] r_rdata, w_rdata_n;
   logic [1:0]  r_rresp, w_rresp_n;
   idx_t        r_raddr, w_raddr_n, w_rnext, w_aridx;
   logic [3:0]  r_rlen, w_rlen_n;
   logic [1:0]  r_rburst, w_rburst_n;
   logic [3:0]  r_rbeat, w_rbeat_n;
   logic        r_rerr, w_rerr_n, w_arerr;

   assign w_aridx = s_araddr[ADDR_WIDTH+1:2];
   assign w_arerr = (s_arsize != 3'b010);
   assign w_rnext = f_next(r_raddr, r_rlen, r_rburst);

   always_comb begin
      w_rstate_n  = r_rstate;
      w_arready_n = r_arready;
      w_rvalid_n  = r_rvalid;
      w_rlast_n   = r_rlast;
      w_rid_n     = r_rid;
      w_rdata_n   = r_rdata;
      w_rresp_n   = r_rresp;
      w_raddr_n   = r_raddr;
      w_rlen_n    = r_rlen;
      w_rburst_n  = r_rburst;
      w_rbeat_n   = r_rbeat;
      w_rerr_n    = r_rerr;
      unique case (r_rstate)
         R_IDLE: begin
            w_arready_n = 1'b1;
            if (s_arvalid && r_arready) begin
               w_rstate_n  = R_DATA;
               w_arready_n = 1'b0;
               w_rvalid_n  = 1'b1;
               w_rid_n     = s_arid;
               w_raddr_n   = w_aridx;
               w_rlen_n    = s_arlen;
               w_rburst_n  = s_arburst;
               w_rbeat_n   = 4'd0;
               w_rerr_n    = w_arerr;
               w_rdata_n   = w_arerr ? 32'h0 : r_mem[w_aridx];
               w_rresp_n   = w_arerr ? 2'b10 : 2'b00;
               w_rlast_n   = (s_arlen == 4'd0);
            end
         end
         R_DATA: begin
            if (s_rready) begin
               if (r_rlast) begin
                  w_rstate_n  = R_IDLE;
                  w_rvalid_n  = 1'b0;
                  w_rlast_n   = 1'b0;
                  w_arready_n = 1'b1;
               end else begin
                  w_raddr_n = w_rnext;
                  w_rbeat_n = r_rbeat + 4'd1;
                  w_rdata_n = r_rerr ? 32'h0 : r_mem[w_rnext];
                  w_rlast_n = ((r_rbeat + 4'd1) == r_rlen);
               end
            end
         end
         default: w_rstate_n = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rid     <= '0;
         r_rdata   <= '0;
         r_rresp   <= '0;
         r_raddr   <= '0;
         r_rlen    <= '0;
         r_rburst  <= '0;
         r_rbeat   <= '0;
         r_rerr    <= 1'b0;
      end else begin
         r_rstate  <= w_rstate_n;
         r_arready <= w_arready_n;
         r_rvalid  <= w_rvalid_n;
         r_rlast   <= w_rlast_n;
         r_rid     <= w_rid_n;
         r_rdata   <= w_rdata_n;
         r_rresp   <= w_rresp_n;
         r_raddr   <= w_raddr_n;
         r_rlen    <= w_rlen_n;
         r_rburst  <= w_rburst_n;
         r_rbeat   <= w_rbeat_n;
         r_rerr    <= w_rerr_n;
      end
   end

   wstate_t     r_wstate, w_wstate_n;
   logic        r_awready, w_awready_n;
   logic        r_wready, w_wready_n;
   logic        r_bvalid, w_bvalid_n;
   logic [3:0]  r_bid, w_bid_n;
   logic [1:0]  r_bresp, w_bresp_n;
   logic [3:0]  r_wid, w_wid_n;
   idx_t        r_waddr, w_waddr_n;
   logic [3:0]  r_wlen, w_wlen_n;
   logic [1:0]  r_wburst, w_wburst_n;
   logic [3:0]  r_wbeat, w_wbeat_n;
   logic        r_werr, w_werr_n;
   logic        w_whs, w_we, w_wend;

   assign w_whs  = (r_wstate == W_DATA) && s_wvalid && r_wready;
   assign w_we   = w_whs && !r_werr;
   assign w_wend = (r_wbeat == r_wlen);

   always_comb begin
      w_wstate_n  = r_wstate;
      w_awready_n = r_awready;
      w_wready_n  = r_wready;
      w_bvalid_n  = r_bvalid;
      w_bid_n     = r_bid;
      w_bresp_n   = r_bresp;
      w_wid_n     = r_wid;
      w_waddr_n   = r_waddr;
      w_wlen_n    = r_wlen;
      w_wburst_n  = r_wburst;
      w_wbeat_n   = r_wbeat;
      w_werr_n    = r_werr;
      unique case (r_wstate)
         W_IDLE: begin
            w_awready_n = 1'b1;
            if (s_awvalid && r_awready) begin
               w_wstate_n  = W_DATA;
               w_awready_n = 1'b0;
               w_wready_n  = 1'b1;
               w_wid_n     = s_awid;
               w_waddr_n   = s_awaddr[ADDR_WIDTH+1:2];
               w_wlen_n    = s_awlen;
               w_wburst_n  = s_awburst;
               w_wbeat_n   = 4'd0;
               w_werr_n    = (s_awsize != 3'b010);
            end
         end
         W_DATA: begin
            if (w_whs) begin
               w_waddr_n = f_next(r_waddr, r_wlen, r_wburst);
               w_wbeat_n = r_wbeat + 4'd1;
               // burst closes on whichever of wlast / final beat comes first
               if (s_wlast || w_wend) begin
                  w_wstate_n = W_RESP;
                  w_wready_n = 1'b0;
                  w_bvalid_n = 1'b1;
                  w_bid_n    = r_wid;
                  w_bresp_n  = (r_werr || (s_wlast != w_wend)) ? 2'b10 : 2'b00;
               end
            end
         end
         W_RESP: begin
            if (s_bready) begin
               w_wstate_n  = W_IDLE;
               w_bvalid_n  = 1'b0;
               w_awready_n = 1'b1;
            end
         end
         default: w_wstate_n = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bid     <= '0;
         r_bresp   <= '0;
         r_wid     <= '0;
         r_waddr   <= '0;
         r_wlen    <= '0;
         r_wburst  <= '0;
         r_wbeat   <= '0;
         r_werr    <= 1'b0;
      end else begin
         r_wstate  <= w_wstate_n;
         r_awready <= w_awready_n;
         r_wready  <= w_wready_n;
         r_bvalid  <= w_bvalid_n;
         r_bid     <= w_bid_n;
         r_bresp   <= w_bresp_n;
         r_wid     <= w_wid_n;
         r_waddr   <= w_waddr_n;
         r_wlen    <= w_wlen_n;
         r_wburst  <= w_wburst_n;
         r_wbeat   <= w_wbeat_n;
         r_werr    <= w_werr_n;
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) r_mem[r_waddr][8*b +: 8] <= s_wdata[8*b +: 8];
      end
   end

   assign s_arready = r_arready;
   assign s_rid     = r_rid;
   assign s_rdata   = r_rdata;
   assign s_rresp   = r_rresp;
   assign s_rlast   = r_rlast;
   assign s_rvalid  = r_rvalid;
   assign s_awready = r_awready;
   assign s_wready  = r_wready;
   assign s_bid     = r_bid;
   assign s_bresp   = r_bresp;
   assign s_bvalid  = r_bvalid;

endmodule
